// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serialized memory path: access size encodings,
// serializer state enum and request decode helpers.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Invalid size, or an access that is not naturally aligned.
    function automatic logic mem_req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] mem_last_idx(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            MEM_SIZE_B: last = 2'd0;
            MEM_SIZE_H: last = 2'd1;
            default:    last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw little-endian load data to 32 bits; shared with the
// cache refill path.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    // Select extension width from the access size.
    always_comb begin
        result = raw;
        case (size)
            MEM_SIZE_B: begin
                if (is_unsigned) begin
                    result = {24'h000000, raw[7:0]};
                end else begin
                    result = {{24{raw[7]}}, raw[7:0]};
                end
            end
            MEM_SIZE_H: begin
                if (is_unsigned) begin
                    result = {16'h0000, raw[15:0]};
                end else begin
                    result = {{16{raw[15]}}, raw[15:0]};
                end
            end
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_byte_serializer.sv
// Serializes one 32-bit load/store into 1, 2 or 4 byte-wide RAM accesses and returns
// a single response; all outputs come straight from flops.
module mem_byte_serializer
    import mem_pkg::*;
#(
    parameter  int SIZE       = 4096,
    localparam int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_wenable,
    input  logic [7:0]            ram_rdata
);

    mem_state_e            state_r;
    logic [1:0]            idx_r;
    logic [1:0]            last_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [31:0]           wdata_r;
    logic [31:0]           acc_r;
    logic                  write_r;
    logic                  uns_r;
    logic [1:0]            size_r;

    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [31:0]           resp_rdata_r;
    logic                  resp_err_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [7:0]            ram_wdata_r;
    logic                  ram_wenable_r;

    logic [1:0]            idx_next_s;
    logic [ADDR_WIDTH-1:0] addr_next_s;
    logic [7:0]            wbyte_next_s;
    logic [31:0]           acc_next_s;
    logic [31:0]           ext_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH];
    assign idx_next_s    = idx_r + 2'd1;
    assign addr_next_s   = base_r + ADDR_WIDTH'(idx_next_s);
    assign wbyte_next_s  = wdata_r[{idx_next_s, 3'b000} +: 8];

    // Merge the byte being read this cycle so the final byte reaches the response.
    always_comb begin
        acc_next_s = acc_r;
        if ((state_r == ST_XFER) && !write_r) begin
            acc_next_s[{idx_r, 3'b000} +: 8] = ram_rdata;
        end else begin
            acc_next_s = acc_r;
        end
    end

    load_extend u_load_extend (
        .raw         (acc_next_s),
        .size        (size_r),
        .is_unsigned (uns_r),
        .result      (ext_s)
    );

    // Request/transfer/response FSM; output registers are loaded one cycle ahead of use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= 2'd0;
            last_r        <= 2'd0;
            base_r        <= '0;
            wdata_r       <= 32'h0000_0000;
            acc_r         <= 32'h0000_0000;
            write_r       <= 1'b0;
            uns_r         <= 1'b0;
            size_r        <= MEM_SIZE_B;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 32'h0000_0000;
            resp_err_r    <= 1'b0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= 8'h00;
            ram_wenable_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        base_r      <= req_addr[ADDR_WIDTH-1:0];
                        size_r      <= req_size;
                        uns_r       <= req_unsigned;
                        wdata_r     <= req_wdata;
                        idx_r       <= 2'd0;
                        last_r      <= mem_last_idx(req_size);
                        acc_r       <= 32'h0000_0000;
                        req_ready_r <= 1'b0;
                        if (mem_req_bad(req_size, req_addr[1:0])) begin
                            state_r      <= ST_DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r       <= ST_XFER;
                            ram_addr_r    <= req_addr[ADDR_WIDTH-1:0];
                            ram_wenable_r <= req_write;
                            ram_wdata_r   <= req_write ? req_wdata[7:0] : 8'h00;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_XFER: begin
                    acc_r <= acc_next_s;
                    if (idx_r == last_r) begin
                        state_r       <= ST_DONE;
                        ram_addr_r    <= '0;
                        ram_wdata_r   <= 8'h00;
                        ram_wenable_r <= 1'b0;
                        resp_valid_r  <= 1'b1;
                        resp_err_r    <= 1'b0;
                        resp_rdata_r  <= write_r ? 32'h0000_0000 : ext_s;
                    end else begin
                        idx_r       <= idx_next_s;
                        ram_addr_r  <= addr_next_s;
                        ram_wdata_r <= write_r ? wbyte_next_s : 8'h00;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    req_ready_r   <= 1'b1;
                    resp_valid_r  <= 1'b0;
                    resp_err_r    <= 1'b0;
                    resp_rdata_r  <= 32'h0000_0000;
                    ram_addr_r    <= '0;
                    ram_wdata_r   <= 8'h00;
                    ram_wenable_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_err    = resp_err_r;
    assign ram_addr    = ram_addr_r;
    assign ram_wdata   = ram_wdata_r;
    assign ram_wenable = ram_wenable_r;

endmodule

// File: tb/tb_mem_byte_serializer.sv
// Bench for mem_byte_serializer: directed and random requests against a byte-array
// memory model, with a behavioural RAM attached to the DUT.
module tb_mem_byte_serializer;

    localparam int SIZE = 4096;
    localparam logic [31:0] MASK = 32'(SIZE - 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_wenable;

    logic [7:0]  ram   [0:SIZE-1];
    logic [7:0]  model [0:SIZE-1];
    logic        ram_init_done = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_byte_serializer #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] seed_byte(input int i);
        int v;
        v = (i * 37 + 11) ^ (i >> 3);
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < SIZE; i++) ram[i] <= seed_byte(i);
        end else if (ram_wenable) begin
            ram[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = ram[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load value from the model: little-endian bytes, then arithmetic extension.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        longint v;
        int n;
        logic [63:0] r;
        n = 1 << s;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(model[(a + 32'(i)) & MASK]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        r = 64'(v);
        return r[31:0];
    endfunction

    // Called #1 after the accepting edge; follows the request to its response.
    task automatic expect_resp(input logic w, input logic [31:0] a, input logic [1:0] s,
                               input logic u, input logic [31:0] d);
        logic bad;
        logic [31:0] exp;
        logic [31:0] dsh;
        int n;
        bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
        if (bad) begin
            check("err_valid", resp_valid, 1);
            check("err_flag", resp_err, 1);
            check("err_rdata", resp_rdata, 0);
            check("err_wen", ram_wenable, 0);
            check("err_ready", req_ready, 0);
        end else begin
            n = 1 << s;
            exp = w ? 32'h0 : model_load(a, s, u);
            for (int i = 0; i < n; i++) begin
                dsh = d >> (8 * i);
                check("xfer_addr", 32'(ram_addr), (a + 32'(i)) & MASK);
                check("xfer_wen", ram_wenable, 32'(w));
                check("xfer_wdata", 32'(ram_wdata), w ? {24'h0, dsh[7:0]} : 32'h0);
                check("xfer_ready", req_ready, 0);
                check("xfer_resp", resp_valid, 0);
                if (w) model[(a + 32'(i)) & MASK] = dsh[7:0];
                @(posedge clk); #1;
            end
            check("resp_valid", resp_valid, 1);
            check("resp_err", resp_err, 0);
            check("resp_rdata", resp_rdata, exp);
            check("resp_ready", req_ready, 0);
            check("resp_wen", ram_wenable, 0);
        end
        @(posedge clk); #1;
        check("post_valid", resp_valid, 0);
        check("post_ready", req_ready, 1);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1)); req_addr = $urandom(); req_wdata = $urandom();
        req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
        expect_resp(w, a, s, u, d);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0] s;
        int bad_bytes;
        for (int i = 0; i < SIZE; i++) model[i] = seed_byte(i);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_err", resp_err, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_wen", ram_wenable, 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_wdata", 32'(ram_wdata), 0);
        @(posedge clk); #1 ram_init_done = 1'b1;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Store word, then signed/unsigned byte and half loads of it.
        issue(1'b1, 32'h010, 2'd2, 1'b0, 32'hDEADBEEF);
        check("t1_byte3", 32'(ram[12'h013]), 32'hDE);
        issue(1'b0, 32'h013, 2'd0, 1'b0, 32'h0);
        issue(1'b0, 32'h013, 2'd0, 1'b1, 32'h0);
        issue(1'b0, 32'h012, 2'd1, 1'b0, 32'h0);
        issue(1'b0, 32'h010, 2'd2, 1'b0, 32'h0);

        // Misaligned and invalid-size requests, including stores.
        issue(1'b0, 32'h011, 2'd1, 1'b0, 32'h0);
        issue(1'b0, 32'h012, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h000, 2'd3, 1'b0, 32'h0);
        issue(1'b1, 32'h011, 2'd1, 1'b0, 32'hCAFEF00D);
        issue(1'b1, 32'h000, 2'd3, 1'b0, 32'hCAFEF00D);

        // Upper address bits ignored.
        issue(1'b1, 32'h1FFC, 2'd2, 1'b0, 32'h8BADF00D);
        issue(1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h1FFE, 2'd1, 1'b0, 32'h0);

        // Reset in the middle of a word store.
        check("t5_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h020; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'h11223344;
        @(posedge clk); #1 req_valid = 1'b0;
        check("t5_b0", 32'(ram_wdata), 32'h44);
        @(posedge clk); #1;
        check("t5_b1", 32'(ram_wdata), 32'h33);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model[12'h020] = 8'h44;
        model[12'h021] = 8'h33;
        #1;
        check("t5_rst_wen", ram_wenable, 0);
        check("t5_rst_addr", 32'(ram_addr), 0);
        check("t5_rst_ready", req_ready, 1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("t5_rst_resp", resp_valid, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_post_resp", resp_valid, 0);
        check("t5_b2_kept", 32'(ram[12'h022]), 32'(seed_byte(32'h022)));
        issue(1'b0, 32'h020, 2'd2, 1'b0, 32'h0);

        // Back-to-back word loads with req_valid held high.
        check("t6_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h010; req_size = 2'd2;
        req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h020;
        expect_resp(1'b0, 32'h010, 2'd2, 1'b0, 32'h0);
        @(posedge clk); #1 req_valid = 1'b0;
        expect_resp(1'b0, 32'h020, 2'd2, 1'b0, 32'h0);

        // Random mix.
        for (int k = 0; k < 80; k++) begin
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            s = 2'($urandom_range(0, 3));
            d = $urandom();
            issue(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), d);
        end

        bad_bytes = 0;
        for (int i = 0; i < SIZE; i++) if (ram[i] !== model[i]) bad_bytes++;
        check("ram_image", 32'(bad_bytes), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_byte_serializer.md
Name: mem_byte_serializer

Overview:
Sits between the load/store unit and port 1 of the byte-wide data RAM. It accepts one 32-bit load or store request at a time. It serializes the request into 1, 2 or 4 consecutive byte accesses, one byte per cycle, in little-endian order. It then returns a single response with the assembled, sign- or zero-extended load data. Misaligned or invalid-size requests are rejected with an error response and never touch the RAM.

Parameters:
SIZE, 4096, RAM depth in bytes; must equal the depth of the attached RAM.
ADDR_WIDTH, $clog2(SIZE), RAM address width (derived localparam, not overridable).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address; bits above ADDR_WIDTH ignored
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = invalid
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned or invalid size; valid with resp_valid
ram_addr  out  ADDR_WIDTH  to RAM addr_1
ram_wdata  out  8  to RAM wdata_1
ram_wenable  out  1  to RAM wenable_1
ram_rdata  in  8  from RAM rdata_1 (combinational read of ram_addr)

Behaviour:
- States: IDLE, XFER, DONE. Reset (rst_n low, asynchronous) forces IDLE, byte index 0, data accumulator 0, latched err 0.
- Outputs while in reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_wenable=0, ram_addr=0, ram_wdata=0.
- IDLE: req_ready=1. On req_valid, latch write, addr[ADDR_WIDTH-1:0], size, unsigned and wdata.
  - Alignment check: size 3 is invalid. Size 1 with addr[0]=1 is misaligned. Size 2 with addr[1:0]!=0 is misaligned.
  - Invalid or misaligned: go to DONE with err=1.
  - Otherwise: go to XFER with N = 1, 2 or 4 and index 0.
- XFER: req_ready=0.
  - ram_addr = (base + index) mod 2^ADDR_WIDTH.
  - Store: ram_wenable=1 and ram_wdata = wdata byte[index].
  - Load: ram_wenable=0, and ram_rdata is captured into accumulator byte[index] at the clock edge.
  - index increments each cycle. After the cycle with index = N-1, go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in DONE.
  - Load, no error: resp_rdata = accumulator extended from 8 or 16 bits per unsigned/sign, or the full word.
  - Store or error: resp_rdata=0. resp_err = latched err.
- ram_wenable=0 in IDLE and DONE; ram_addr and ram_wdata are 0 outside XFER.
- Latency: request accepted at edge T; resp_valid high during cycle T+N+1 (error: cycle T+1). Next request can be accepted in cycle T+N+2. Throughput for a word access is 1 per 6 cycles.
- No response backpressure: the consumer must take resp in its valid cycle.
- Reset mid-XFER: aborts immediately and no response is produced. Bytes already written stay written.
- Inputs req_* are ignored outside IDLE, and they are not required to be held stable after acceptance.

Decomposition:
- Shared package mem_pkg: size encodings (MEM_SIZE_B=0, MEM_SIZE_H=1, MEM_SIZE_W=2) and the state enum.
- One sub-module, load_extend: a combinational block taking 32-bit raw data, size and unsigned, and producing the 32-bit extended result. It is reused by the future cache path.

Test Plan:
1. Store word 0xDEADBEEF at 0x010 → ram writes 0xEF@0x010, 0xBE@0x011, 0xAD@0x012, 0xDE@0x013 on consecutive cycles; resp_valid at T+5, err=0, rdata=0.
2. Load byte from 0x013 after test 1, signed → rdata=0xFFFFFFDE. Same load with unsigned → 0x000000DE. Load half at 0x012, signed → 0xFFFFDEAD.
3. Load half at 0x011 and load word at 0x012 → resp_err=1 at T+1, no ram_wenable pulse, RAM contents unchanged. req_size=3 at 0x000 → resp_err=1.
4. Address 0x1FFC with SIZE=4096 → ram_addr 0xFFC..0xFFF. Upper bits are ignored and stay within range.
5. Assert rst_n low during cycle 2 of a word store of 0x11223344 at 0x020 → bytes 0x44@0x020 and 0x33@0x021 written, 0x022 and 0x023 unchanged, no resp_valid. After release req_ready=1 and the next load word at 0x020 completes normally.
6. Back-to-back: hold req_valid high with two word loads → second is accepted only in the cycle after resp_valid; req_ready is low in all XFER and DONE cycles.
